alu_operand_feeder: RTL and testbench
=====================================

ALU_OPERAND_FEEDER -- requirements
Module: alu_operand_feeder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning the number of WAIT cycles without alu_ready before the command is aborted (used only with ALU_FEEDER_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  feeder accepts a command this cycle.
REQ-006 cmd_op  input  2  ALU op code for the command.
REQ-007 cmd_a  input  8  first operand.
REQ-008 cmd_b  input  8  second operand.
REQ-009 alu_op  output  2  op code driven to the ALU op_codes input.
REQ-010 alu_in  output  8  operand byte driven to the ALU in bus.
REQ-011 alu_valid  output  1  qualifies alu_in.
REQ-012 alu_o  input  8  ALU result byte.
REQ-013 alu_ready  input  1  ALU result available.
REQ-014 res_valid  output  1  result held for the host.
REQ-015 res_ready  input  1  host consumes the result.
REQ-016 res_data  output  16  {high byte, low byte} of the ALU result.
REQ-017 res_err  output  1  command aborted by timeout.

Function
REQ-018 States: IDLE, SEND_A, SEND_B, WAIT, CAP_HI, DONE; the state is encoded in a single registered variable.
REQ-019 IDLE: cmd_ready=1; on cmd_valid=1, cmd_op/cmd_a/cmd_b are latched and the state moves to SEND_A; cmd_ready=0 in all other states.
REQ-020 SEND_A: alu_valid=1, alu_in=latched A, for exactly one cycle, then SEND_B.
REQ-021 SEND_B: alu_valid=1, alu_in=latched B, for exactly one cycle, then WAIT.
REQ-022 alu_op holds the latched op code from SEND_A through DONE; outside those states it holds its last value (0 after reset).
REQ-023 alu_valid=0 and alu_in=0 in IDLE, WAIT, CAP_HI and DONE.
REQ-024 WAIT: on the first cycle alu_ready=1, alu_o is captured as res_data[7:0] and the state moves to CAP_HI.
REQ-025 CAP_HI: alu_o is captured as res_data[15:8] unconditionally, then DONE.
REQ-026 alu_ready is ignored in every state except WAIT.
REQ-027 DONE: res_valid=1; res_data and res_err are held stable until res_ready=1, then IDLE.
REQ-028 Latency: command acceptance to res_valid is 4 cycles plus the number of WAIT cycles.
REQ-029 Back-to-back operation: cmd_ready is asserted on the cycle after the res_ready handshake; cmd_valid presented during DONE is not accepted.
REQ-030 res_data is updated only in WAIT/CAP_HI and is otherwise held, including in IDLE.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, cmd_ready=1, alu_valid=0, alu_in=0, alu_op=0, res_valid=0, res_data=0, res_err=0, timeout counter=0.
REQ-032 Reset asserted in any state aborts the command with no result delivered; the first command after reset release is accepted normally.

Configuration
REQ-033 Macro ALU_FEEDER_TIMEOUT_EN defined: an 8-bit-or-wider counter clears on WAIT entry and increments each WAIT cycle; when it reaches TIMEOUT_CYCLES with alu_ready=0, the state goes to DONE with res_err=1 and res_data=0.
REQ-034 res_err is cleared on each command acceptance.
REQ-035 Macro undefined: no counter is built, WAIT persists until alu_ready, and res_err is tied to 0.

Verification
REQ-036 Reset release, op=01, A=3, B=2 accepted -> alu_valid high 2 cycles carrying 3 then 2; alu_op=01.
REQ-037 alu_ready pulsed 5 cycles after SEND_B with alu_o=0x06 then 0x00 -> res_valid=1, res_data=0x0006, res_err=0.
REQ-038 res_ready held low 10 cycles in DONE -> res_data stable, cmd_ready=0, a new cmd_valid is ignored; res_ready=1 -> IDLE on the next cycle.
REQ-039 rst asserted during WAIT -> all outputs at reset values immediately, without waiting for a clock edge; the next command completes correctly.
REQ-040 ALU_FEEDER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, alu_ready never asserted -> res_valid=1, res_err=1, res_data=0 after exactly 8 WAIT cycles.
REQ-041 alu_ready=1 during IDLE/SEND_A -> no capture, no state change; the result is captured only from the WAIT-state pulse.

Source files
------------

// File: rtl/alu_operand_feeder.sv
// alu_operand_feeder: sequences one host command into a byte-serial ALU.
// It sends operand A, then operand B, waits for the ALU to answer, captures the
// low and high result bytes and holds the 16-bit result until the host takes it.
// Optional feature: define ALU_FEEDER_TIMEOUT_EN to abort a command whose ALU
// answer does not arrive within TIMEOUT_CYCLES WAIT cycles (res_err=1, res_data=0).
module alu_operand_feeder #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_in,
  output logic        alu_valid,
  input  logic [7:0]  alu_o,
  input  logic        alu_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT   = 3'd3,
    CAP_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [1:0]  op_q;
  logic [15:0] data_q;
  logic        accept;
  logic        timeout_hit;

  assign accept = (state == IDLE) && cmd_valid;

`ifdef ALU_FEEDER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // WAIT-cycle counter: cleared on the way into WAIT, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == SEND_B) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // The final allowed WAIT cycle is the one where the counter shows TIMEOUT_CYCLES-1.
  assign timeout_hit = (state == WAIT) && !alu_ready &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag: cleared when a command is accepted, set when it is aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign res_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; alu_ready only matters while waiting for the ALU.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SEND_A;
      SEND_A:  state_nxt = SEND_B;
      SEND_B:  state_nxt = WAIT;
      WAIT: begin
        if (alu_ready)        state_nxt = CAP_HI;
        else if (timeout_hit) state_nxt = DONE;
      end
      CAP_HI:  state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state; operand bus is zero when not qualified.
  always_comb begin
    cmd_ready = (state == IDLE);
    alu_valid = 1'b0;
    alu_in    = 8'h00;
    res_valid = (state == DONE);
    case (state)
      SEND_A: begin
        alu_valid = 1'b1;
        alu_in    = a_q;
      end
      SEND_B: begin
        alu_valid = 1'b1;
        alu_in    = b_q;
      end
      default: ;
    endcase
  end

  // Operand latches: only observed in SEND_A/SEND_B, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= cmd_a;
      b_q <= cmd_b;
    end
  end

  // Op code and result registers; the result only changes in WAIT/CAP_HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'b00;
      data_q <= 16'h0000;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
      end
      if ((state == WAIT) && alu_ready) begin
        data_q[7:0] <= alu_o;
      end else if (timeout_hit) begin
        data_q <= 16'h0000;
      end else if (state == CAP_HI) begin
        data_q[15:8] <= alu_o;
      end
    end
  end

  assign alu_op   = op_q;
  assign res_data = data_q;

endmodule

// File: tb/tb_alu_operand_feeder.sv
// Testbench for alu_operand_feeder: random commands, an ALU responder that
// answers after a random delay, and scoreboard monitors for both the ALU
// operand bus and the host result port.
module tb_alu_operand_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  alu_op;
  logic [7:0]  alu_in;
  logic        alu_valid;
  logic [7:0]  alu_o;
  logic        alu_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] b;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    logic        e;
  } res_t;

  beat_t alu_q[$];
  res_t  res_q[$];

  alu_operand_feeder #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_op    (alu_op),
    .alu_in    (alu_in),
    .alu_valid (alu_valid),
    .alu_o     (alu_o),
    .alu_ready (alu_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU-side monitor: every qualified byte must match the next expected operand.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_valid) begin
        if (alu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL alu_beat_unexpected: got alu_in=%0h, expected no beat", alu_in);
        end else begin
          beat_t e;
          e = alu_q.pop_front();
          check("alu_in", alu_in, e.b);
          check("alu_op", alu_op, e.op);
        end
      end else begin
        check("alu_in_unqualified", alu_in, 8'h00);
      end
    end
  end

  // Host-side monitor: results in order, stable while held, idle hold afterwards.
  res_t        held;
  logic        in_done = 1'b0;
  logic        hs = 1'b0;
  logic [15:0] last_data = 16'h0000;

  always @(negedge clk) begin
    if (rst) begin
      in_done   = 1'b0;
      hs        = 1'b0;
      last_data = 16'h0000;
    end else begin
      if (hs) begin
        check("cmd_ready_after_handshake", cmd_ready, 1'b1);
        check("res_valid_after_handshake", res_valid, 1'b0);
        hs = 1'b0;
      end
      if (res_valid) begin
        if (!in_done) begin
          if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected: got res_data=%0h, expected no result", res_data);
            held.d = res_data;
            held.e = res_err;
          end else begin
            held = res_q.pop_front();
            check("res_data", res_data, held.d);
            check("res_err", res_err, held.e);
          end
          in_done = 1'b1;
        end else begin
          check("res_data_hold", res_data, held.d);
          check("res_err_hold", res_err, held.e);
        end
        check("cmd_ready_in_done", cmd_ready, 1'b0);
        if (res_ready) begin
          hs        = 1'b1;
          in_done   = 1'b0;
          last_data = held.d;
        end
      end else if (cmd_ready) begin
        check("res_data_idle_hold", res_data, last_data);
      end
    end
  end

  // Offer a command and wait (bounded) until the feeder takes it.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_d, input logic exp_e);
    int k;
    beat_t ba;
    beat_t bb;
    res_t  r;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    k = 0;
    while (!cmd_ready && k < 20) begin
      step();
      k++;
    end
    check("accept_wait_bound", (k < 20), 1'b1);
    ba.op = op; ba.b = a;
    bb.op = op; bb.b = b;
    alu_q.push_back(ba);
    alu_q.push_back(bb);
    r.d = exp_d;
    r.e = exp_e;
    res_q.push_back(r);
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_a     = 8'($urandom);
    cmd_b     = 8'($urandom);
  endtask

  // Hold the result for some cycles while offering an ignored command, then take it.
  task automatic drain(input int hold);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      alu_ready = 1'($urandom);
      alu_o     = 8'($urandom);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    alu_ready = 1'($urandom);
    alu_o     = 8'($urandom);
  endtask

  // One full command with the ALU answering after d idle WAIT cycles.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] lo, input logic [7:0] hi, input int d, input int hold);
    int k;
    issue(op, a, b, {hi, lo}, 1'b0);
    // SEND_A and SEND_B: alu_ready here must be ignored.
    for (int i = 0; i < 2; i++) begin
      alu_ready = 1'($urandom);
      alu_o     = 8'($urandom);
      step();
    end
    for (int i = 0; i < d; i++) begin
      alu_ready = 1'b0;
      alu_o     = 8'($urandom);
      step();
    end
    alu_ready = 1'b1;
    alu_o     = lo;
    step();
    alu_ready = 1'($urandom);
    alu_o     = hi;
    step();
    k = 0;
    while (!res_valid && k < 50) begin
      step();
      k++;
    end
    check("result_latency_extra", k, 0);
    drain(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    alu_o     = 8'h00;
    alu_ready = 1'b0;
    res_ready = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_alu_valid", alu_valid, 1'b0);
    check("rst_alu_in", alu_in, 8'h00);
    check("rst_alu_op", alu_op, 2'b00);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_res_err", res_err, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();

    // Directed: op=01, A=3, B=2, ALU answers 0x06/0x00 after 5 cycles, host waits 10.
    run_cmd(2'b01, 8'd3, 8'd2, 8'h06, 8'h00, 5, 10);

    // Reset in the middle of WAIT aborts the command with no result.
    issue(2'b10, 8'hA5, 8'h5A, 16'hBEEF, 1'b0);
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cmd_ready", cmd_ready, 1'b1);
    check("async_rst_alu_valid", alu_valid, 1'b0);
    check("async_rst_alu_in", alu_in, 8'h00);
    check("async_rst_alu_op", alu_op, 2'b00);
    check("async_rst_res_valid", res_valid, 1'b0);
    check("async_rst_res_data", res_data, 16'h0000);
    check("async_rst_res_err", res_err, 1'b0);
    res_q.delete();
    alu_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    run_cmd(2'b11, 8'h12, 8'h34, 8'h9C, 8'hE7, 0, 0);

`ifdef ALU_FEEDER_TIMEOUT_EN
    // ALU never answers: abort after exactly 8 WAIT cycles with an error result.
    issue(2'b01, 8'h77, 8'h88, 16'h0000, 1'b1);
    alu_ready = 1'b0;
    step();
    step();
    k = 0;
    while (!res_valid && k < 50) begin
      step();
      k++;
    end
    check("timeout_wait_cycles", k, 8);
    drain(3);
    run_cmd(2'b10, 8'h01, 8'h02, 8'h33, 8'h44, 2, 1);
`endif

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      k = int'($urandom_range(0, 2));
      for (int i = 0; i < k; i++) begin
        alu_ready = 1'($urandom);
        alu_o     = 8'($urandom);
        step();
      end
    end

    for (int i = 0; i < 4; i++) step();
    check("alu_queue_drained", alu_q.size(), 0);
    check("res_queue_drained", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
